reg_file_param: RTL
===================

# reg_file_param

Parametrised integer register file for the RISC-V core, succeeding the fixed 64-bit, 32-entry, single-write-port file. Adds configurable width and depth, a second write port for dual-retire/load-writeback, optional write-to-read bypass, and an asynchronous reset that clears every register. A simulation-only register print is replaced by a synthesisable dump engine: a small FSM that streams every register over a valid/ready interface for debug and trace capture.

## Interface
- XLEN, 64, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2; index 0 hardwired to zero.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return array contents only.
- AW (derived, not overridable) = clog2(NREGS).

- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr, rs2_addr  in  AW  read addresses.
- rs1_data, rs2_data  out  XLEN  read data, combinational.
- we0, rd0_addr, rd0_data  in  1/AW/XLEN  write port 0.
- we1, rd1_addr, rd1_data  in  1/AW/XLEN  write port 1; higher priority.
- dump_start  in  1  one-cycle request to start a dump.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump beat available.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  AW  register index of the current beat.
- dump_data  out  XLEN  contents of register dump_idx.
- dump_last  out  1  dump_valid and dump_idx == NREGS-1.

## Operation
- Reset (rst_n low, asynchronous): all registers 0; FSM in IDLE; dump_busy, dump_valid and dump_last 0; dump_idx 0. dump_data reads register 0, so it is also 0.
- Writes: on a rising clk edge, port p writes rdp_data to rdp_addr when wep=1 and rdp_addr != 0.
  - A write to index 0 is discarded; register 0 always reads 0.
  - If both ports are enabled to the same nonzero address, port 1's data is stored.
- Reads: rsN_data = 0 if rsN_addr == 0. Otherwise:
  - With BYPASS=1: the enabled writer matching rsN_addr is forwarded, port 1 first, then port 0.
  - In all other cases the array value is returned.
- Dump FSM, two states:
  - IDLE: dump_valid=0, dump_busy=0. dump_start=1 moves to DUMP with dump_idx=0.
  - DUMP: dump_valid=1, dump_busy=1. dump_data = array[dump_idx] (no bypass). On dump_valid and dump_ready:
    - if dump_idx == NREGS-1: go to IDLE and reset dump_idx to 0;
    - otherwise increment dump_idx.
  - dump_start is ignored in DUMP.
  - Writes continue normally during a dump. A beat carries the array value at the cycle it is accepted.
  - dump_ready low stalls the dump indefinitely; dump_idx and dump_valid hold.
- Reset mid-dump aborts immediately: IDLE, outputs cleared, no partial beat completes.
- Widths: no arithmetic on data. dump_idx counts 0..NREGS-1 only and never wraps past NREGS-1.

## Timing
- Read latency 0: read data is combinational from the address and array (and from the write ports when BYPASS=1).
- Write-to-read visibility:
  - BYPASS=1: same cycle.
  - BYPASS=0: the cycle after the write edge.
- dump_start sampled at edge T gives dump_valid=1, dump_idx=0 in cycle T+1.
- With dump_ready held high, a full dump takes NREGS cycles.
  - dump_valid falls the cycle after the beat with dump_last=1 is accepted.
  - A new dump_start is accepted in that same cycle.
- Total cycles for a dump = NREGS plus the number of stalled cycles.

## Test plan
- Reset and x0: deassert rst_n; then write 0xDEAD to index 0 via both ports → rs1_data from addr 0 is 0, and every register reads 0.
- Dual-write conflict: we0 writes addr 5 = 0x11 and we1 writes addr 5 = 0x22 in the same cycle → next cycle rs1(5) = 0x22. Separate addresses 3=0xA and 4=0xB → both stored.
- Bypass: BYPASS=1, we1 writes addr 7 = 0x1234 while rs2_addr=7 → rs2_data = 0x1234 in the same cycle. BYPASS=0 → old value that cycle, 0x1234 next cycle.
- Full dump: preload reg k = k*3, pulse dump_start, hold dump_ready=1 → 32 beats, idx 0..31, data k*3. dump_last only on idx 31; dump_busy low the cycle after.
- Backpressure and concurrent write: toggle dump_ready every other cycle and write reg 10 = 0xFF before beat 10 is accepted → idx holds while ready is low, and beat 10 carries 0xFF. dump_start pulses during the dump are ignored.
- Reset mid-dump: assert rst_n low at beat 12 → dump_valid, dump_busy and dump_idx go to 0 immediately. After release, a new dump starts at idx 0 with all data 0.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised integer register file with two write ports, optional write-to-read
// bypass and a valid/ready dump engine that streams every register for debug capture.
module reg_file_param #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we0,
  input  logic [AW-1:0]   rd0_addr,
  input  logic [XLEN-1:0] rd0_data,
  input  logic            we1,
  input  logic [AW-1:0]   rd1_addr,
  input  logic [XLEN-1:0] rd1_data,
  input  logic            dump_start,
  output logic            dump_busy,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last
);

  // state    | meaning
  // S_IDLE   | no dump in progress, waiting for dump_start
  // S_DUMP   | presenting register dump_idx, advancing on each accepted beat
  typedef enum logic {S_IDLE = 1'b0, S_DUMP = 1'b1} state_e;

  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;

  // Port 1 is applied last so it wins a same-address conflict; index 0 is never written.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (we0 && (rd0_addr != '0)) regs_d[rd0_addr] = rd0_data;
    if (we1 && (rd1_addr != '0)) regs_d[rd1_addr] = rd1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] arr_val,
    input logic            w0,
    input logic [AW-1:0]   a0,
    input logic [XLEN-1:0] d0,
    input logic            w1,
    input logic [AW-1:0]   a1,
    input logic [XLEN-1:0] d1
  );
    logic [XLEN-1:0] val;
    val = arr_val;
    if (addr == '0) val = '0;
    else if (BYPASS && w1 && (a1 == addr)) val = d1;
    else if (BYPASS && w0 && (a0 == addr)) val = d0;
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr, regs_q[rs1_addr], we0, rd0_addr, rd0_data,
                         we1, rd1_addr, rd1_data);
    rs2_data = read_port(rs2_addr, regs_q[rs2_addr], we0, rd0_addr, rd0_data,
                         we1, rd1_addr, rd1_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Dump beats read the array directly: a beat carries what is stored, never a bypassed value.
  assign dump_valid = (state_q == S_DUMP);
  assign dump_busy  = (state_q == S_DUMP);
  assign dump_idx   = idx_q;
  assign dump_data  = regs_q[idx_q];
  assign dump_last  = dump_valid && (idx_q == IDX_LAST);

endmodule
